// File: rtl/sharp_spi_rx.sv
// Memory-LCD serial receiver: oversamples SPI in the sys_ck domain and decodes write/VCOM/all-clear frames.
// Optional build macro SHARP_RX_MSB_FIRST_EN stores address and pixel fields MSB-first.
module sharp_spi_rx #(
  parameter int PIXELS  = 144,
  parameter int ADDR_W  = 8,
  parameter int CMD_W   = 8,
  parameter int TRAIL_W = 16
) (
  input  logic              sys_ck,
  input  logic              rst,
  input  logic              spi_ck,
  input  logic              spi_cs,
  input  logic              spi_data,
  output logic [PIXELS-1:0] line_data,
  output logic [ADDR_W-1:0] line_addr,
  output logic              line_valid,
  output logic              clear_all,
  output logic              vcom,
  output logic              frame_err
);

  localparam int MAX_AC = (ADDR_W > CMD_W) ? ADDR_W : CMD_W;
  localparam int MAX_PT = (PIXELS > TRAIL_W) ? PIXELS : TRAIL_W;
  localparam int MAX_F  = (MAX_AC > MAX_PT) ? MAX_AC : MAX_PT;
  localparam int CNT_W  = $clog2(MAX_F) + 1;
  localparam int PIW    = $clog2(PIXELS);
  localparam int AIW    = (ADDR_W > 1) ? $clog2(ADDR_W) : 1;

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, TRAIL, DRAIN} state_t;

  state_t             state, state_next;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic               ck_s1, ck_s2, ck_hist, cs_s1, cs_s2, dat_s1, dat_s2;
  logic [1:0]         settle;
  logic               armed;
  logic               rise;
  logic [2:0]         mode_reg, mode_cur;
  logic [ADDR_W-1:0]  addr_sh;
  logic [PIXELS-1:0]  pix_sh, pix_full;
  logic [PIW-1:0]     p_idx;
  logic [AIW-1:0]     a_idx;
  logic               cmd_last, addr_last, data_last, trail_last;
  logic               line_valid_next, clear_all_next, frame_err_next, vcom_next;

  // Synchronisers; 'armed' demands a genuine synced CS low after reset before a frame may start.
  always_ff @(posedge sys_ck or posedge rst) begin
    if (rst) begin
      {ck_s1, ck_s2, ck_hist, cs_s1, cs_s2, dat_s1, dat_s2} <= '0;
      settle <= '0;
      armed  <= 1'b0;
    end else begin
      ck_s1   <= spi_ck;
      ck_s2   <= ck_s1;
      ck_hist <= ck_s2;
      cs_s1   <= spi_cs;
      cs_s2   <= cs_s1;
      dat_s1  <= spi_data;
      dat_s2  <= dat_s1;
      settle  <= {settle[0], 1'b1};
      armed   <= armed | (settle[1] & ~cs_s2);
    end
  end

  assign rise       = ck_s2 & ~ck_hist;
  assign cmd_last   = (cnt == CNT_W'(CMD_W - 1));
  assign addr_last  = (cnt == CNT_W'(ADDR_W - 1));
  assign data_last  = (cnt == CNT_W'(PIXELS - 1));
  assign trail_last = (cnt == CNT_W'(TRAIL_W - 1));

`ifdef SHARP_RX_MSB_FIRST_EN
  assign p_idx = PIW'(PIXELS - 1) - PIW'(cnt);
  assign a_idx = AIW'(ADDR_W - 1) - AIW'(cnt);
`else
  assign p_idx = PIW'(cnt);
  assign a_idx = AIW'(cnt);
`endif

  // Mode and pixel views that already include the bit arriving this cycle.
  always_comb begin
    mode_cur = mode_reg;
    if (cnt < CNT_W'(3)) mode_cur[cnt[1:0]] = dat_s2;
    pix_full = pix_sh;
    pix_full[p_idx] = dat_s2;
  end

  // State register
  always_ff @(posedge sys_ck or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      line_valid <= 1'b0;
      clear_all  <= 1'b0;
      frame_err  <= 1'b0;
      vcom       <= 1'b0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      line_valid <= line_valid_next;
      clear_all  <= clear_all_next;
      frame_err  <= frame_err_next;
      vcom       <= vcom_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (armed) state_next = CMD;
      CMD:   if (rise && cmd_last) state_next = mode_cur[0] ? ADDR : DRAIN;
      ADDR:  if (rise && addr_last) state_next = DATA;
      DATA:  if (rise && data_last) state_next = TRAIL;
      TRAIL: if (rise && trail_last) state_next = ADDR;
      DRAIN: state_next = DRAIN;
      default: state_next = IDLE;
    endcase
    if (!cs_s2) state_next = IDLE;

    cnt_next = cnt;
    if (state_next != state)
      cnt_next = '0;
    else if (rise && state != IDLE && state != DRAIN)
      cnt_next = cnt + CNT_W'(1);
  end

  // Output logic
  always_comb begin
    line_valid_next = cs_s2 && state == DATA && rise && data_last;
    clear_all_next  = cs_s2 && state == CMD && rise && cmd_last && !mode_cur[0] && mode_cur[2];
    frame_err_next  = !cs_s2 && ((state == ADDR && cnt != '0) || state == DATA);
    vcom_next       = vcom;
    if (cs_s2 && state == CMD && rise && cmd_last) vcom_next = mode_cur[1];
  end

  // Field shadows; published lines only change on a completed data field.
  always_ff @(posedge sys_ck or posedge rst) begin
    if (rst) begin
      mode_reg  <= '0;
      addr_sh   <= '0;
      pix_sh    <= '0;
      line_data <= '0;
      line_addr <= '0;
    end else begin
      if (rise && cs_s2) begin
        case (state)
          CMD:  mode_reg <= mode_cur;
          ADDR: addr_sh[a_idx] <= dat_s2;
          DATA: pix_sh[p_idx] <= dat_s2;
          default: ;
        endcase
      end
      if (line_valid_next) begin
        line_data <= pix_full;
        line_addr <= addr_sh;
      end
    end
  end

endmodule
